rgb_fade_engine: RTL and testbench
==================================

# rgb_fade_engine

Duty-value conditioning stage between the slot register bank and the PWM core in the RGB lab design. It takes the three 8-bit colour targets held in the register bank and produces the duty words the PWM core consumes. Instead of passing targets straight through, it ramps the duties toward them in fixed steps (fade mode) or sweeps a shared brightness envelope up and down (breathe mode). All stepping is gated by an external rate strobe, typically a divided tick in the 1 kHz control domain.

## Interface
Parameters:
- WIDTH, 8: width of target and duty words.
- STEP, 1: increment per tick, applied both to channel duties (fade) and to the envelope level (breathe); 1..2^WIDTH.

Ports:
- clk  in  1  block clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  global enable; when 0, ticks are ignored and all state holds.
- tick  in  1  one-cycle step strobe; one step per high cycle when en=1.
- mode  in  1  0 = fade, 1 = breathe; sampled only on a qualified tick.
- tgt_r, tgt_g, tgt_b  in  WIDTH  channel targets from the register bank.
- duty_r, duty_g, duty_b  out  WIDTH  registered duties to the PWM core.
- settled  out  1  registered; 1 when in FADE and all duties equal their targets.
- breathe_dir  out  1  registered; 1 while the envelope rises (BR_UP), else 0.

## Operation
- Qualified tick: qt = tick & en. All state changes occur only on clk edges with qt=1, except settled, which is re-evaluated every cycle.
- State machine: FADE, BR_UP, BR_DOWN. Reset state is FADE.
- FADE:
  - Per channel, cur < tgt: cur <= min(cur+STEP, tgt).
  - Per channel, cur > tgt: cur <= max(cur-STEP, tgt).
  - Per channel, cur == tgt: cur holds.
  - Arithmetic is done in WIDTH+1 bits, so there is no wrap at 2^WIDTH-1 or below 0.
  - duty_x = cur_x.
- FADE -> BR_DOWN on qt with mode=1. The envelope level lvl (WIDTH+1 bits, range 0..2^WIDTH) is loaded with 2^WIDTH, so the first breathe output equals the targets and there is no visible jump.
- BR_DOWN:
  - On qt, lvl <= max(lvl-STEP, 0).
  - When the new lvl is 0, the next state is BR_UP.
- BR_UP:
  - On qt, lvl <= min(lvl+STEP, 2^WIDTH).
  - When the new lvl is 2^WIDTH, the next state is BR_DOWN.
- Breathe output:
  - duty_x = (tgt_x * lvl) >> WIDTH, computed with a 2*WIDTH+1 bit product and truncated to WIDTH bits.
  - lvl = 2^WIDTH yields exactly tgt_x; lvl = 0 yields 0.
  - cur_x tracks duty_x each cycle in breathe states.
- BR_UP/BR_DOWN -> FADE on qt with mode=0. cur_x keeps the last displayed duty, and fading toward the targets starts on the following qt.
- Target changes take effect immediately in the next computation. No latching of targets.
- settled:
  - Registered, computed as (state==FADE) & (next cur_x == tgt_x for all three channels).
  - Forced to 0 in breathe states.

## Timing
- Reset (rst=1 at clk edge) sets:
  - duty_r/g/b = 0, cur = 0, lvl = 0
  - state = FADE, settled = 0, breathe_dir = 0
- rst has priority over qt on the same edge.
- Latency: duty outputs change on the clk edge that samples qt=1 and are visible one cycle after tick is asserted. Breathe multiply is combinational into the output register, with no extra cycle.
- settled rises on the same edge as the final duty update in FADE. From reset with constant targets it rises one cycle after reset deasserts.
- Mode switch and level step on the same qt: the transition edge only reloads or retains values and does not also step.
- Reset mid-fade or mid-breathe returns everything to reset values in one cycle.
- tick held high for N cycles produces N steps.

## Test plan
- Fade up: reset, then tgt_r=10, STEP=1, en=1, 12 single ticks -> duty_r = 1,2,…,10,10,10; settled=1 from the 10th tick edge; duty_g=duty_b=0 throughout.
- Clamp and no wrap: STEP=100, cur_r=250 (set by prior fade), tgt_r=255, then tick -> duty_r=255. Then tgt_r=3, 3 ticks -> duty_r = 155, 55, 3.
- en gating and reset priority: en=0 with 5 ticks -> duties unchanged. Then rst=1 and tick=1 on the same edge -> all duties 0, state FADE.
- Breathe envelope: tgt=(200,100,0), STEP=64, settled, then mode=1 and tick:
  - lvl=256, duty=(200,100,0).
  - Next 4 ticks: duty_r = 150, 100, 50, 0, and breathe_dir goes to 1 after lvl reaches 0.
  - Next 4 ticks: duty_r = 50, 100, 150, 200.
- Exit breathe: mid-envelope at duty_r=100, set mode=0 and tick -> duty_r holds 100, settled=0. With STEP=64, ticks then fade: 164, 200, settled=1.
- Target change mid-fade: fading tgt_r 0->50 at duty_r=20, change tgt_r to 5 -> next ticks give 19, 18, … down to 5 with no overshoot.

Source files
------------

// File: rtl/rgb_fade_engine.sv
// Duty conditioning between the slot register bank and the PWM core.
// Ramps channel duties toward their targets (fade) or sweeps a shared brightness envelope (breathe).
module rgb_fade_engine #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             mode,
  input  logic [WIDTH-1:0] tgt_r,
  input  logic [WIDTH-1:0] tgt_g,
  input  logic [WIDTH-1:0] tgt_b,
  output logic [WIDTH-1:0] duty_r,
  output logic [WIDTH-1:0] duty_g,
  output logic [WIDTH-1:0] duty_b,
  output logic             settled,
  output logic             breathe_dir
);

  typedef enum logic [1:0] {
    FADE    = 2'd0,
    BR_UP   = 2'd1,
    BR_DOWN = 2'd2
  } state_t;

  localparam logic [WIDTH:0]   FULL   = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   STEP_L = (WIDTH+1)'(STEP);
  localparam logic [WIDTH+1:0] STEP_F = (WIDTH+2)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH:0]   lvl_q, lvl_d;
  logic [WIDTH-1:0] duty_r_q, duty_r_d;
  logic [WIDTH-1:0] duty_g_q, duty_g_d;
  logic [WIDTH-1:0] duty_b_q, duty_b_d;
  logic             settled_q, settled_d;
  logic             breathe_dir_q, breathe_dir_d;
  logic             qt;
  logic             lvl_step;

  // Two guard bits keep cur+STEP and the tgt+STEP compare free of wrap.
  function automatic logic [WIDTH-1:0] fade_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
    logic [WIDTH+1:0] c, t, s;
    c = {2'b00, cur};
    t = {2'b00, tgt};
    s = c;
    if (c < t)      s = (c + STEP_F > t) ? t : c + STEP_F;
    else if (c > t) s = (c < t + STEP_F) ? t : c - STEP_F;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] t,
                                             input logic [WIDTH:0]   l);
    logic [2*WIDTH:0] p;
    p = {{(WIDTH+1){1'b0}}, t} * {{WIDTH{1'b0}}, l};
    return p[2*WIDTH-1:WIDTH];
  endfunction

  assign qt = tick & en;

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;
    lvl_step = 1'b0;
    if (qt) begin
      case (state_q)
        FADE: begin
          if (mode) begin
            // Envelope starts at full scale so the first breathe duty equals the target.
            state_d  = BR_DOWN;
            lvl_d    = FULL;
            duty_r_d = tgt_r;
            duty_g_d = tgt_g;
            duty_b_d = tgt_b;
          end else begin
            duty_r_d = fade_step(duty_r_q, tgt_r);
            duty_g_d = fade_step(duty_g_q, tgt_g);
            duty_b_d = fade_step(duty_b_q, tgt_b);
          end
        end
        BR_DOWN: begin
          if (!mode) begin
            state_d = FADE;
          end else begin
            lvl_step = 1'b1;
            lvl_d    = (lvl_q > STEP_L) ? lvl_q - STEP_L : '0;
            if (lvl_d == '0) state_d = BR_UP;
          end
        end
        BR_UP: begin
          if (!mode) begin
            state_d = FADE;
          end else begin
            lvl_step = 1'b1;
            lvl_d    = (FULL - lvl_q > STEP_L) ? lvl_q + STEP_L : FULL;
            if (lvl_d == FULL) state_d = BR_DOWN;
          end
        end
        default: state_d = FADE;
      endcase
    end
    if (lvl_step) begin
      duty_r_d = scale(tgt_r, lvl_d);
      duty_g_d = scale(tgt_g, lvl_d);
      duty_b_d = scale(tgt_b, lvl_d);
    end
    settled_d     = (state_d == FADE) && (duty_r_d == tgt_r) &&
                    (duty_g_d == tgt_g) && (duty_b_d == tgt_b);
    breathe_dir_d = (state_d == BR_UP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FADE;
      lvl_q         <= '0;
      duty_r_q      <= '0;
      duty_g_q      <= '0;
      duty_b_q      <= '0;
      settled_q     <= 1'b0;
      breathe_dir_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lvl_q         <= lvl_d;
      duty_r_q      <= duty_r_d;
      duty_g_q      <= duty_g_d;
      duty_b_q      <= duty_b_d;
      settled_q     <= settled_d;
      breathe_dir_q <= breathe_dir_d;
    end
  end

  assign duty_r      = duty_r_q;
  assign duty_g      = duty_g_q;
  assign duty_b      = duty_b_q;
  assign settled     = settled_q;
  assign breathe_dir = breathe_dir_q;

endmodule

// File: tb/tb_rgb_fade_engine.sv
// Bench for rgb_fade_engine: three instances (STEP 1, 100, 64) share stimulus and are
// checked against a behavioural model plus fixed scenario values.
module tb_rgb_fade_engine;

  localparam int M_FADE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;

  logic       clk = 1'b0;
  logic       rst, en, tick, mode;
  logic [7:0] tgt_r, tgt_g, tgt_b;
  logic [7:0] dr[3], dg[3], db[3];
  logic       st[3], bd[3];

  int total = 0;
  int bad   = 0;

  int steps[3] = '{1, 100, 64};
  int m_state[3];
  int m_lvl[3];
  int m_cur[3][3];
  bit m_set[3];
  bit m_dir[3];

  always #5 clk = ~clk;

  rgb_fade_engine #(.WIDTH(8), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .mode(mode),
    .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b),
    .duty_r(dr[0]), .duty_g(dg[0]), .duty_b(db[0]),
    .settled(st[0]), .breathe_dir(bd[0]));

  rgb_fade_engine #(.WIDTH(8), .STEP(100)) u_s100 (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .mode(mode),
    .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b),
    .duty_r(dr[1]), .duty_g(dg[1]), .duty_b(db[1]),
    .settled(st[1]), .breathe_dir(bd[1]));

  rgb_fade_engine #(.WIDTH(8), .STEP(64)) u_s64 (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .mode(mode),
    .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b),
    .duty_r(dr[2]), .duty_g(dg[2]), .duty_b(db[2]),
    .settled(st[2]), .breathe_dir(bd[2]));

  // Reference behaviour: what each instance should hold after a clock edge with the current inputs.
  task automatic model_update();
    int tv[3];
    bit all_eq;
    tv[0] = int'(tgt_r);
    tv[1] = int'(tgt_g);
    tv[2] = int'(tgt_b);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_state[k] = M_FADE;
        m_lvl[k]   = 0;
        for (int c = 0; c < 3; c++) m_cur[k][c] = 0;
        m_set[k] = 0;
        m_dir[k] = 0;
      end else begin
        if (en && tick) begin
          if (m_state[k] == M_FADE) begin
            if (mode) begin
              m_state[k] = M_DOWN;
              m_lvl[k]   = 256;
              for (int c = 0; c < 3; c++) m_cur[k][c] = tv[c];
            end else begin
              for (int c = 0; c < 3; c++) begin
                if (m_cur[k][c] < tv[c])
                  m_cur[k][c] = (m_cur[k][c] + steps[k] > tv[c]) ? tv[c] : m_cur[k][c] + steps[k];
                else if (m_cur[k][c] > tv[c])
                  m_cur[k][c] = (m_cur[k][c] - steps[k] < tv[c]) ? tv[c] : m_cur[k][c] - steps[k];
              end
            end
          end else if (!mode) begin
            m_state[k] = M_FADE;
          end else begin
            if (m_state[k] == M_DOWN) begin
              m_lvl[k] = m_lvl[k] - steps[k];
              if (m_lvl[k] <= 0) begin
                m_lvl[k]   = 0;
                m_state[k] = M_UP;
              end
            end else begin
              m_lvl[k] = m_lvl[k] + steps[k];
              if (m_lvl[k] >= 256) begin
                m_lvl[k]   = 256;
                m_state[k] = M_DOWN;
              end
            end
            for (int c = 0; c < 3; c++) m_cur[k][c] = (tv[c] * m_lvl[k]) / 256;
          end
        end
        all_eq = 1;
        for (int c = 0; c < 3; c++) if (m_cur[k][c] != tv[c]) all_eq = 0;
        m_set[k] = (m_state[k] == M_FADE) && all_eq;
        m_dir[k] = (m_state[k] == M_UP);
      end
    end
  endtask

  function automatic logic [25:0] exp_vec(int k);
    return {8'(m_cur[k][0]), 8'(m_cur[k][1]), 8'(m_cur[k][2]), m_set[k], m_dir[k]};
  endfunction

  function automatic logic [25:0] got_vec(int k);
    return {dr[k], dg[k], db[k], st[k], bd[k]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic pulse();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; tick = 1'b0; mode = 1'b0;
    tgt_r = 8'd0; tgt_g = 8'd0; tgt_b = 8'd0;
    cyc();
    cyc();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got_vec(k) !== 26'd0) begin
        bad++;
        $display("FAIL reset_state inst%0d got=%h exp=%h", k, got_vec(k), 26'd0);
      end
    end
    rst = 1'b0;
    cyc();
    total++;
    if (st[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_settle got=%b exp=1", st[0]);
    end
  endtask

  task automatic test_fade_up();
    int exp_r;
    tgt_r = 8'd10; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      pulse();
      exp_r = (i < 10) ? i : 10;
      total++;
      if (dr[0] !== 8'(exp_r) || st[0] !== (i >= 10) || dg[0] !== 8'd0 || db[0] !== 8'd0) begin
        bad++;
        $display("FAIL fade_up tick%0d got r=%0d g=%0d b=%0d s=%b exp r=%0d g=0 b=0 s=%b",
                 i, dr[0], dg[0], db[0], st[0], exp_r, i >= 10);
      end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (got_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL fade_up_model inst%0d got=%h exp=%h", k, got_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_clamp();
    int seq[3] = '{155, 55, 3};
    tgt_r = 8'd250;
    repeat (3) pulse();
    tgt_r = 8'd255;
    pulse();
    total++;
    if (dr[1] !== 8'd255) begin
      bad++;
      $display("FAIL clamp_top got=%0d exp=255", dr[1]);
    end
    tgt_r = 8'd3;
    for (int i = 0; i < 3; i++) begin
      pulse();
      total++;
      if (dr[1] !== 8'(seq[i])) begin
        bad++;
        $display("FAIL clamp_down step%0d got=%0d exp=%0d", i, dr[1], seq[i]);
      end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (got_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL clamp_model inst%0d got=%h exp=%h", k, got_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_en_reset();
    tgt_r = 8'd200; tgt_g = 8'd77;
    en = 1'b0; tick = 1'b1;
    repeat (5) cyc();
    tick = 1'b0;
    total++;
    if (dr[1] !== 8'd3 || dg[1] !== 8'd0) begin
      bad++;
      $display("FAIL en_gate got r=%0d g=%0d exp r=3 g=0", dr[1], dg[1]);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got_vec(k) !== exp_vec(k)) begin
        bad++;
        $display("FAIL en_gate_model inst%0d got=%h exp=%h", k, got_vec(k), exp_vec(k));
      end
    end
    rst = 1'b1; en = 1'b1; tick = 1'b1;
    cyc();
    rst = 1'b0; tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got_vec(k) !== 26'd0) begin
        bad++;
        $display("FAIL rst_priority inst%0d got=%h exp=%h", k, got_vec(k), 26'd0);
      end
    end
  endtask

  task automatic test_breathe();
    int down_r[4] = '{150, 100, 50, 0};
    int up_r[4]   = '{50, 100, 150, 200};
    tgt_r = 8'd200; tgt_g = 8'd100; tgt_b = 8'd0; mode = 1'b0;
    repeat (4) pulse();
    total++;
    if (dr[2] !== 8'd200 || st[2] !== 1'b1) begin
      bad++;
      $display("FAIL br_presettle got r=%0d s=%b exp r=200 s=1", dr[2], st[2]);
    end
    mode = 1'b1;
    pulse();
    total++;
    if (dr[2] !== 8'd200 || dg[2] !== 8'd100 || db[2] !== 8'd0 || st[2] !== 1'b0 || bd[2] !== 1'b0) begin
      bad++;
      $display("FAIL br_enter got r=%0d g=%0d b=%0d s=%b d=%b exp r=200 g=100 b=0 s=0 d=0",
               dr[2], dg[2], db[2], st[2], bd[2]);
    end
    for (int i = 0; i < 8; i++) begin
      pulse();
      total++;
      if (i < 4 && (dr[2] !== 8'(down_r[i]) || bd[2] !== (i == 3))) begin
        bad++;
        $display("FAIL br_down step%0d got r=%0d d=%b exp r=%0d d=%b", i, dr[2], bd[2], down_r[i], i == 3);
      end else if (i >= 4 && (dr[2] !== 8'(up_r[i-4]) || bd[2] !== (i < 7))) begin
        bad++;
        $display("FAIL br_up step%0d got r=%0d d=%b exp r=%0d d=%b", i - 4, dr[2], bd[2], up_r[i-4], i < 7);
      end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (got_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL br_model inst%0d got=%h exp=%h", k, got_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_exit_breathe();
    repeat (2) pulse();
    total++;
    if (dr[2] !== 8'd100) begin
      bad++;
      $display("FAIL exit_mid got=%0d exp=100", dr[2]);
    end
    mode = 1'b0;
    pulse();
    total++;
    if (dr[2] !== 8'd100 || st[2] !== 1'b0 || bd[2] !== 1'b0) begin
      bad++;
      $display("FAIL exit_hold got r=%0d s=%b d=%b exp r=100 s=0 d=0", dr[2], st[2], bd[2]);
    end
    pulse();
    total++;
    if (dr[2] !== 8'd164 || st[2] !== 1'b0) begin
      bad++;
      $display("FAIL exit_fade1 got r=%0d s=%b exp r=164 s=0", dr[2], st[2]);
    end
    pulse();
    total++;
    if (dr[2] !== 8'd200 || st[2] !== 1'b1) begin
      bad++;
      $display("FAIL exit_fade2 got r=%0d s=%b exp r=200 s=1", dr[2], st[2]);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got_vec(k) !== exp_vec(k)) begin
        bad++;
        $display("FAIL exit_model inst%0d got=%h exp=%h", k, got_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_tgt_change();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tgt_r = 8'd50; tgt_g = 8'd0; tgt_b = 8'd0; mode = 1'b0;
    repeat (20) pulse();
    total++;
    if (dr[0] !== 8'd20) begin
      bad++;
      $display("FAIL tgt_chg_start got=%0d exp=20", dr[0]);
    end
    tgt_r = 8'd5;
    for (int i = 1; i <= 16; i++) begin
      pulse();
      total++;
      if (dr[0] !== 8'((i <= 15) ? 20 - i : 5) || st[0] !== (i >= 15)) begin
        bad++;
        $display("FAIL tgt_chg step%0d got r=%0d s=%b exp r=%0d s=%b",
                 i, dr[0], st[0], (i <= 15) ? 20 - i : 5, i >= 15);
      end
    end
  endtask

  task automatic test_back_to_back();
    tgt_r = 8'd100;
    tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (got_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL b2b_model inst%0d got=%h exp=%h", k, got_vec(k), exp_vec(k));
        end
      end
    end
    tick = 1'b0;
    total++;
    if (dr[0] !== 8'd10) begin
      bad++;
      $display("FAIL b2b_steps got=%0d exp=10", dr[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 79) == 0);
      en   = ($urandom_range(0, 7) != 0);
      tick = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) begin
        tgt_r = 8'($urandom_range(0, 255));
        tgt_g = 8'($urandom_range(0, 255));
        tgt_b = 8'($urandom_range(0, 255));
      end
      cyc();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (got_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL random_model cyc%0d inst%0d got=%h exp=%h", i, k, got_vec(k), exp_vec(k));
        end
      end
    end
    rst = 1'b0; tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fade_up();
    test_clamp();
    test_en_reset();
    test_breathe();
    test_exit_breathe();
    test_tgt_change();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
